ripple_count_monitor: RTL and testbench

- Synchronous consumer sitting directly downstream of the 4-bit ripple down-counter. It takes the counter's raw q bus, whose bits change at staggered times and glitch through intermediate codes, into the system clock domain.
- A value is accepted only after it has been stable for a set number of samples.
- It tracks the count sequence, pulses on each new value, on reaching zero and on each 0->15 wrap, and counts wraps.
- Any accepted value that is not exactly one below the previous one sets a sticky skip error.

---
 rtl/ripple_count_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_ripple_count_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor.sv
// Samples the raw q bus of a 4-bit ripple down-counter into clk, accepts
// values only after they are stable, and flags pulses, wraps and skipped steps.
module ripple_count_monitor #(
    parameter int WIDTH      = 4,
    parameter int WRAP_W     = 8,
    parameter int STABLE_CNT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              en,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  cnt_val,
    output logic              cnt_upd,
    output logic              zero_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              skip_err,
    output logic              tracking
);

    // state | meaning
    // IDLE  | monitor disabled, filter cleared, cnt_val/wrap_cnt hold
    // SEED  | waiting for the first stable value, loaded without a skip check
    // TRACK | following the count, checking each accepted step is a decrement

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam int              RUN_W   = 3;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
    localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(STABLE_CNT - 1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [RUN_W-1:0] run;

    logic             same;
    logic             accept;
    logic             acc_v;

    logic [WIDTH-1:0]  val_nxt;
    logic              upd_nxt;
    logic              zero_nxt;
    logic              wrap_nxt;
    logic [WRAP_W-1:0] wc_nxt;
    logic              skip_set;
    logic              skip_nxt;
    logic [WIDTH-1:0]  dec_val;

    // ------------------------------------------------------------------
    // Two-flop synchronizer and stability filter
    // ------------------------------------------------------------------
    assign same = (s2 == cand);

    // run saturates at STABLE_CNT, so the accept compare matches once per run
    always_comb begin
        accept = 1'b0;
        if (STABLE_CNT == 1) begin
            accept = !same || (run == '0);
        end else begin
            accept = same && (run == RUN_ACC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            run  <= '0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            if (state == IDLE) begin
                cand <= '0;
                run  <= '0;
            end else if (!same) begin
                cand <= s2;
                run  <= RUN_W'(1);
            end else if (run != RUN_MAX) begin
                run <= run + 1'b1;
            end
        end
    end

    // en is evaluated before an accept on the same edge
    assign acc_v = accept && en && (state != IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = SEED;
                end
            end
            SEED: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (acc_v) begin
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (!en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values
    // ------------------------------------------------------------------
    assign dec_val = cnt_val - 1'b1;

    always_comb begin
        val_nxt  = cnt_val;
        upd_nxt  = 1'b0;
        zero_nxt = 1'b0;
        wrap_nxt = 1'b0;
        wc_nxt   = wrap_cnt;
        skip_set = 1'b0;
        if (acc_v) begin
            case (state)
                SEED: begin
                    val_nxt  = s2;
                    upd_nxt  = 1'b1;
                    zero_nxt = (s2 == '0);
                end
                TRACK: begin
                    // An equal value is a glitch that settled back; ignore it
                    if (s2 != cnt_val) begin
                        val_nxt  = s2;
                        upd_nxt  = 1'b1;
                        zero_nxt = (s2 == '0);
                        if (s2 == dec_val) begin
                            if (cnt_val == '0) begin
                                wrap_nxt = 1'b1;
                                wc_nxt   = wrap_cnt + 1'b1;
                            end
                        end else begin
                            skip_set = 1'b1;
                        end
                    end
                end
                default: begin
                    val_nxt = cnt_val;
                end
            endcase
        end
        skip_nxt = skip_set ? 1'b1 : (clr_err ? 1'b0 : skip_err);
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_val    <= '0;
            cnt_upd    <= 1'b0;
            zero_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            skip_err   <= 1'b0;
        end else begin
            cnt_val    <= val_nxt;
            cnt_upd    <= upd_nxt;
            zero_pulse <= zero_nxt;
            wrap_pulse <= wrap_nxt;
            wrap_cnt   <= wc_nxt;
            skip_err   <= skip_nxt;
        end
    end

    assign tracking = (state == TRACK);

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: a vector table for steady sequences
// plus hand-written sequences for reset, clear/set races, wraps and enable drops.
module tb_ripple_count_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       en;
    logic       clr_err;
    logic [3:0] cnt_val;
    logic       cnt_upd;
    logic       zero_pulse;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic       skip_err;
    logic       tracking;

    int n_chk;
    int n_fail;

    ripple_count_monitor #(
        .WIDTH(4),
        .WRAP_W(8),
        .STABLE_CNT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cnt_in(cnt_in),
        .en(en),
        .clr_err(clr_err),
        .cnt_val(cnt_val),
        .cnt_upd(cnt_upd),
        .zero_pulse(zero_pulse),
        .wrap_pulse(wrap_pulse),
        .wrap_cnt(wrap_cnt),
        .skip_err(skip_err),
        .tracking(tracking)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cin;
        logic       en;
        int         hold;
        logic [3:0] val;
        int         upd;
        int         zero;
        int         wrap;
        logic       skip;
        logic       trk;
        logic [7:0] wc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] cin, logic e, int hold, logic [3:0] val,
                                int upd, int zero, int wrap, logic skip, logic trk,
                                logic [7:0] wc);
        vec_t v;
        v.cin = cin; v.en = e; v.hold = hold; v.val = val; v.upd = upd;
        v.zero = zero; v.wrap = wrap; v.skip = skip; v.trk = trk; v.wc = wc;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " cnt_val"}, 32'(cnt_val), 32'h0);
        chk({tag, " cnt_upd"}, 32'(cnt_upd), 32'h0);
        chk({tag, " zero_pulse"}, 32'(zero_pulse), 32'h0);
        chk({tag, " wrap_pulse"}, 32'(wrap_pulse), 32'h0);
        chk({tag, " wrap_cnt"}, 32'(wrap_cnt), 32'h0);
        chk({tag, " skip_err"}, 32'(skip_err), 32'h0);
        chk({tag, " tracking"}, 32'(tracking), 32'h0);
    endtask

    initial begin
        int u;
        int z;
        int w;
        int exp_wc;

        n_chk  = 0;
        n_fail = 0;

        // steady-sequence table; pulse counts are over each row's hold window
        vecs.push_back(mk(4'hA, 1'b0, 2, 4'hA, 0, 0, 0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(4'hF, 1'b1, 6, 4'hF, 1, 0, 0, 1'b0, 1'b1, 8'd0));
        for (int v = 14; v >= 0; v--) begin
            vecs.push_back(mk(4'(v), 1'b1, 6, 4'(v), 1, (v == 0) ? 1 : 0, 0,
                              1'b0, 1'b1, 8'd0));
        end
        vecs.push_back(mk(4'hF, 1'b1, 6, 4'hF, 1, 0, 1, 1'b0, 1'b1, 8'd1));
        vecs.push_back(mk(4'h8, 1'b0, 2, 4'hF, 0, 0, 0, 1'b0, 1'b0, 8'd1));
        vecs.push_back(mk(4'h8, 1'b1, 6, 4'h8, 1, 0, 0, 1'b0, 1'b1, 8'd1));
        vecs.push_back(mk(4'h6, 1'b1, 1, 4'h8, 0, 0, 0, 1'b0, 1'b1, 8'd1));
        vecs.push_back(mk(4'h7, 1'b1, 6, 4'h7, 1, 0, 0, 1'b0, 1'b1, 8'd1));
        vecs.push_back(mk(4'h9, 1'b0, 2, 4'h7, 0, 0, 0, 1'b0, 1'b0, 8'd1));
        vecs.push_back(mk(4'h9, 1'b1, 6, 4'h9, 1, 0, 0, 1'b0, 1'b1, 8'd1));
        vecs.push_back(mk(4'h5, 1'b1, 6, 4'h5, 1, 0, 0, 1'b1, 1'b1, 8'd1));

        // reset held with live inputs, then first seed after release
        rst = 1'b0; cnt_in = 4'hA; en = 1'b1; clr_err = 1'b0;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick(); tick(); tick();
        chk("seed early cnt_val", 32'(cnt_val), 32'h0);
        chk("seed early cnt_upd", 32'(cnt_upd), 32'h0);
        tick();
        chk("seed cnt_val", 32'(cnt_val), 32'hA);
        chk("seed cnt_upd", 32'(cnt_upd), 32'h1);
        chk("seed tracking", 32'(tracking), 32'h1);
        tick();
        chk("seed cnt_upd width", 32'(cnt_upd), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cnt_in = vecs[i].cin;
            en     = vecs[i].en;
            u = 0; z = 0; w = 0;
            for (int h = 0; h < vecs[i].hold; h++) begin
                tick();
                u += int'(cnt_upd);
                z += int'(zero_pulse);
                w += int'(wrap_pulse);
            end
            chk($sformatf("row%0d cnt_val", i), 32'(cnt_val), 32'(vecs[i].val));
            chk($sformatf("row%0d upd_count", i), 32'(u), 32'(vecs[i].upd));
            chk($sformatf("row%0d zero_count", i), 32'(z), 32'(vecs[i].zero));
            chk($sformatf("row%0d wrap_count", i), 32'(w), 32'(vecs[i].wrap));
            chk($sformatf("row%0d skip_err", i), 32'(skip_err), 32'(vecs[i].skip));
            chk($sformatf("row%0d tracking", i), 32'(tracking), 32'(vecs[i].trk));
            chk($sformatf("row%0d wrap_cnt", i), 32'(wrap_cnt), 32'(vecs[i].wc));
        end

        // clr_err alone clears, then set wins when a skip lands on the same edge
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr skip_err", 32'(skip_err), 32'h0);
        cnt_in = 4'h2;
        tick(); tick(); tick();
        chk("race pre skip_err", 32'(skip_err), 32'h0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("race cnt_val", 32'(cnt_val), 32'h2);
        chk("race cnt_upd", 32'(cnt_upd), 32'h1);
        chk("race skip_err", 32'(skip_err), 32'h1);

        // run wrap_cnt up to 255 via 0 -> 15 steps
        exp_wc = 1;
        w = 0;
        for (int k = 0; k < 254; k++) begin
            cnt_in = 4'h0;
            for (int h = 0; h < 4; h++) begin tick(); w += int'(wrap_pulse); end
            cnt_in = 4'hF;
            for (int h = 0; h < 4; h++) begin tick(); w += int'(wrap_pulse); end
            exp_wc++;
        end
        chk("preload wrap pulses", 32'(w), 32'd254);
        chk("preload wrap_cnt", 32'(wrap_cnt), 32'(exp_wc[7:0]));
        cnt_in = 4'h0;
        tick(); tick(); tick(); tick();
        cnt_in = 4'hF;
        tick(); tick(); tick();
        chk("rollover pre wrap_pulse", 32'(wrap_pulse), 32'h0);
        tick();
        chk("rollover wrap_pulse", 32'(wrap_pulse), 32'h1);
        chk("rollover wrap_cnt", 32'(wrap_cnt), 32'h0);
        chk("rollover cnt_upd", 32'(cnt_upd), 32'h1);
        tick();
        chk("rollover wrap_pulse width", 32'(wrap_pulse), 32'h0);

        // disable mid-sequence, then reseed without a skip check
        cnt_in = 4'h3;
        for (int h = 0; h < 6; h++) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("pre-idle cnt_val", 32'(cnt_val), 32'h3);
        chk("pre-idle skip_err", 32'(skip_err), 32'h0);
        en = 1'b0; cnt_in = 4'h1; u = 0;
        for (int h = 0; h < 6; h++) begin tick(); u += int'(cnt_upd); end
        chk("idle upd_count", 32'(u), 32'h0);
        chk("idle cnt_val", 32'(cnt_val), 32'h3);
        chk("idle tracking", 32'(tracking), 32'h0);
        en = 1'b1; u = 0;
        for (int h = 0; h < 6; h++) begin tick(); u += int'(cnt_upd); end
        chk("reseed upd_count", 32'(u), 32'h1);
        chk("reseed cnt_val", 32'(cnt_val), 32'h1);
        chk("reseed skip_err", 32'(skip_err), 32'h0);
        chk("reseed tracking", 32'(tracking), 32'h1);

        // en drop on the accept edge loses the accept
        cnt_in = 4'h0;
        tick(); tick(); tick();
        en = 1'b0; tick();
        chk("drop cnt_val", 32'(cnt_val), 32'h1);
        chk("drop cnt_upd", 32'(cnt_upd), 32'h0);
        chk("drop zero_pulse", 32'(zero_pulse), 32'h0);
        chk("drop tracking", 32'(tracking), 32'h0);
        en = 1'b1; z = 0;
        for (int h = 0; h < 6; h++) begin tick(); z += int'(zero_pulse); end
        chk("seed0 cnt_val", 32'(cnt_val), 32'h0);
        chk("seed0 zero_count", 32'(z), 32'h1);

        // wrap once more, then reset in the middle of TRACK
        cnt_in = 4'hF;
        for (int h = 0; h < 6; h++) tick();
        chk("final wrap_cnt", 32'(wrap_cnt), 32'h1);
        cnt_in = 4'hE;
        tick(); tick();
        rst = 1'b0; tick();
        chk_all_zero("midrst");
        tick(); tick(); tick(); tick();
        chk("midrst held cnt_val", 32'(cnt_val), 32'h0);
        chk("midrst held tracking", 32'(tracking), 32'h0);
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
